// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencer for one external Shiftreg instance. Together with that instance
//   it forms a full-duplex serial link: a parallel word taken on a valid/ready
//   handshake is loaded into the shift register. The word is shifted out one
//   bit per CLK_DIV clocks while sampled serial input bits are shifted in.
//   The received word is presented with a one-cycle rx_valid pulse.
//
// Parameters
//   WIDTH      word width, must match the Shiftreg instance (>= 2)
//   DIRECTION  must match the Shiftreg instance; 0 = LSB first, 1 = MSB first
//   CLK_DIV    clk cycles per serial bit (even, >= 2)
//   GAP        forced idle time after each word (0..15)
//
// Configuration macro
//   SHIFT_SEQ_CTRL_LOOPBACK_EN  defined: the sampled bit comes from
//                               i_sr_shiftout and i_ser_din is ignored.
//                               Not defined: the sampled bit comes from i_ser_din.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   i_tx_data        word to send
//   i_tx_valid       tx word valid
//   o_tx_ready       controller can accept a word (IDLE)
//   i_abort          synchronous abort of the word in flight
//   o_rx_data        last received word, held until the next rx_valid
//   o_rx_valid       one-cycle pulse, o_rx_data updated
//   o_busy           high in every state except IDLE
//   o_ser_clk        serial clock, low in the first half of a bit, high in the second
//   i_ser_din        serial input, sampled on the ser_clk rise
//   o_ser_dout       serial output (pass-through of i_sr_shiftout)
//   o_sr_en          Shiftreg enable
//   o_sr_load        Shiftreg parallel load
//   o_sr_data        Shiftreg parallel data (= i_tx_data)
//   o_sr_shiftin     Shiftreg serial input (sampled bit register)
//   o_sr_sclr        Shiftreg active-low synchronous clear (registered)
//   i_sr_q           Shiftreg parallel output
//   i_sr_shiftout    Shiftreg serial output
// -----------------------------------------------------------------------------
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | waiting for a word, tx_ready high
//  BIT    | shifting: div counts through one bit period, bit counts bits
//  DONE   | one cycle, received word presented with rx_valid
//  GAP    | forced idle before tx_ready returns (skipped when GAP = 0)
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIRECTION = 0,
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_ser_clk,
  input  logic             i_ser_din,
  output logic             o_ser_dout,
  output logic             o_sr_en,
  output logic             o_sr_load,
  output logic [WIDTH-1:0] o_sr_data,
  output logic             o_sr_shiftin,
  output logic             o_sr_sclr,
  input  logic [WIDTH-1:0] i_sr_q,
  input  logic             i_sr_shiftout
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LD   = 4'(GAP);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("shift_seq_ctrl: WIDTH must be >= 2");
  end
  if ((DIRECTION != 0) && (DIRECTION != 1)) begin : g_bad_dir
    $error("shift_seq_ctrl: DIRECTION must be 0 or 1");
  end
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
    $error("shift_seq_ctrl: CLK_DIV must be even and >= 2");
  end
  if ((GAP < 0) || (GAP > 15)) begin : g_bad_gap
    $error("shift_seq_ctrl: GAP must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIT  = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [3:0]       r_gap;
  logic             r_sample;
  logic             r_ser_clk;
  logic             r_sr_sclr;
  logic [WIDTH-1:0] r_rx_data;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [BIT_W-1:0] w_bit_nxt;
  logic [3:0]       w_gap_nxt;
  logic             w_sample_nxt;
  logic             w_ser_clk_nxt;
  logic             w_sr_sclr_nxt;
  logic [WIDTH-1:0] w_rx_data_nxt;
  logic             w_sample_src;
  logic             w_aborting;

`ifdef SHIFT_SEQ_CTRL_LOOPBACK_EN
  // Internal loopback: the pin is not used at all in this build.
  logic w_unused_ser_din;
  assign w_unused_ser_din = i_ser_din;
  assign w_sample_src     = i_sr_shiftout;
`else
  assign w_sample_src     = i_ser_din;
`endif

  // abort only acts on a word in flight; in IDLE it is ignored.
  assign w_aborting = i_abort && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_sample  <= 1'b0;
      r_ser_clk <= 1'b0;
      r_sr_sclr <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit     <= w_bit_nxt;
      r_gap     <= w_gap_nxt;
      r_sample  <= w_sample_nxt;
      r_ser_clk <= w_ser_clk_nxt;
      r_sr_sclr <= w_sr_sclr_nxt;
      r_rx_data <= w_rx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_bit_nxt     = r_bit;
    w_gap_nxt     = r_gap;
    w_sample_nxt  = r_sample;
    w_rx_data_nxt = r_rx_data;
    w_sr_sclr_nxt = 1'b1;
    o_tx_ready    = 1'b0;
    o_sr_en       = 1'b0;
    o_sr_load     = 1'b0;
    o_rx_valid    = 1'b0;

    if (w_aborting) begin
      // Abort wins over the shift edge and the DONE capture; the register
      // is cleared on the following cycle through sr_sclr.
      w_state_nxt   = S_IDLE;
      w_div_nxt     = '0;
      w_bit_nxt     = '0;
      w_gap_nxt     = '0;
      w_sr_sclr_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          o_tx_ready = 1'b1;
          w_bit_nxt  = '0;
          if (i_tx_valid) begin
            o_sr_load   = 1'b1;
            o_sr_en     = 1'b1;
            w_state_nxt = S_BIT;
            w_div_nxt   = '0;
          end
        end

        S_BIT: begin
          if (r_div == DIV_HALF) begin
            w_sample_nxt = w_sample_src;
          end
          if (r_div == DIV_LAST) begin
            o_sr_en   = 1'b1;
            w_div_nxt = '0;
            w_bit_nxt = r_bit + BIT_W'(1);
            if (r_bit == BIT_LAST) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_div_nxt = r_div + DIV_W'(1);
          end
        end

        S_DONE: begin
          o_rx_valid    = 1'b1;
          w_rx_data_nxt = i_sr_q;
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LD;
          end else begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
          end
        end

        S_GAP: begin
          // Down-counter: the GAP state lasts until terminal count 0,
          // so tx_ready returns GAP+2 cycles after the rx_valid pulse.
          if (r_gap == 4'd0) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_gap_nxt = r_gap - 4'd1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_gap_nxt   = '0;
        end
      endcase
    end

    // Serial clock is a register derived from the next divider phase, so the
    // pin has no combinational glitches and is low outside BIT.
    w_ser_clk_nxt = (w_state_nxt == S_BIT) && (w_div_nxt >= DIV_HALF);
  end

  // During the DONE cycle the received word is shown directly from the
  // shift register so it is valid together with the rx_valid pulse.
  assign o_rx_data    = o_rx_valid ? i_sr_q : r_rx_data;
  assign o_busy       = (r_state != S_IDLE);
  assign o_ser_clk    = r_ser_clk;
  assign o_ser_dout   = i_sr_shiftout;
  assign o_sr_data    = i_tx_data;
  assign o_sr_shiftin = r_sample;
  assign o_sr_sclr    = r_sr_sclr;

endmodule
